// File: rtl/nco_voice_bank_if.sv
// Control/output bundle of the NCO voice bank: control-word writes and
// hard-sync requests flow in, wavetable addresses flow out.
interface nco_voice_bank_if #(
  parameter int VOICES = 4,
  parameter int ACC_W  = 18,
  parameter int SMP_W  = 7,
  parameter int WAV_W  = 6,
  parameter int OCT_W  = 3,
  parameter int VW     = $clog2(VOICES)
);
  logic                           i_input_latch_write_enable;
  logic [VW-1:0]                  i_write_voice;
  logic [ACC_W+OCT_W+WAV_W-1:0]   i_input;
  logic [VOICES-1:0]              i_phase_reset;
  logic [WAV_W+SMP_W-1:0]         o_waveram_address;
  logic [VW-1:0]                  o_voice;
  logic                           o_valid;

  // Controller side: writes control words, reads addresses.
  modport master (
    output i_input_latch_write_enable, i_write_voice, i_input, i_phase_reset,
    input  o_waveram_address, o_voice, o_valid
  );

  // Voice bank side.
  modport slave (
    input  i_input_latch_write_enable, i_write_voice, i_input, i_phase_reset,
    output o_waveram_address, o_voice, o_valid
  );
endinterface

// File: rtl/nco_voice_bank.sv
// Time-multiplexed bank of NCOs. One shared phase/sample/wave datapath
// services one voice per clock in round-robin order and emits the
// {wave, sample} wavetable address of that voice one edge later.
module nco_voice_bank #(
  parameter int VOICES = 4,
  parameter int ACC_W  = 18,
  parameter int SMP_W  = 7,
  parameter int WAV_W  = 6,
  parameter int OCT_W  = 3,
  parameter int VW     = $clog2(VOICES)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  nco_voice_bank_if.slave    bus
);

  localparam int CW = ACC_W + OCT_W + WAV_W;

  // Per-voice state. Everything clears asynchronously, so these stay in
  // fabric registers rather than block RAM.
  logic [CW-1:0]    ctrl_reg   [VOICES];
  logic [ACC_W-1:0] phase_reg  [VOICES];
  logic [SMP_W-1:0] sample_reg [VOICES];
  logic [WAV_W-1:0] wave_reg   [VOICES];

  logic [VW-1:0]    slot_reg;

  // One-hot decodes of the write target and of the serviced slot.
  logic [VOICES-1:0] write_sel;
  logic [VOICES-1:0] slot_sel;

  genvar gi;
  generate
    for (gi = 0; gi < VOICES; gi++) begin : g_decode
      assign write_sel[gi] = bus.i_input_latch_write_enable &&
                             (bus.i_write_voice == VW'(gi));
      assign slot_sel[gi]  = (slot_reg == VW'(gi));
    end
  endgenerate

  // Fields of the serviced voice's control word (old word on a same-slot write).
  logic [CW-1:0]    cur_ctrl;
  logic [ACC_W-1:0] cur_inc;
  logic [OCT_W-1:0] cur_oct;
  logic [WAV_W-1:0] cur_req;
  logic             cur_sync;

  assign cur_ctrl = ctrl_reg[slot_reg];
  assign cur_inc  = cur_ctrl[ACC_W-1:0];
  assign cur_oct  = cur_ctrl[ACC_W +: OCT_W];
  assign cur_req  = cur_ctrl[ACC_W+OCT_W +: WAV_W];
  assign cur_sync = bus.i_phase_reset[slot_reg];

  logic [ACC_W:0]   phase_sum;
  logic             carry;
  logic [SMP_W-1:0] step;
  logic [SMP_W:0]   sample_sum;
  logic             wrap;
  logic [ACC_W-1:0] phase_next;
  logic [SMP_W-1:0] sample_next;
  logic [WAV_W-1:0] wave_next;

  // Shared read-modify-write datapath for the serviced voice.
  always_comb begin
    phase_sum   = {1'b0, phase_reg[slot_reg]} + {1'b0, cur_inc};
    carry       = phase_sum[ACC_W];
    // Octaves at or above the sample width freeze the sample address.
    step        = '0;
    if (int'(cur_oct) < SMP_W) begin
      step = SMP_W'(1) << cur_oct;
    end
    sample_sum  = {1'b0, sample_reg[slot_reg]} + {1'b0, (carry ? step : {SMP_W{1'b0}})};
    wrap        = sample_sum[SMP_W];

    phase_next  = phase_sum[ACC_W-1:0];
    sample_next = sample_sum[SMP_W-1:0];
    wave_next   = wave_reg[slot_reg];
    // A wave switch only lands on a true wrap so the waveform stays continuous.
    if (wrap) begin
      wave_next = cur_req;
    end
    // Hard sync overrides the free-running result for this slot.
    if (cur_sync) begin
      phase_next  = '0;
      sample_next = '0;
      wave_next   = cur_req;
    end
  end

  // Control-word latch and write-back of the serviced voice's state.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int v = 0; v < VOICES; v++) begin
        ctrl_reg[v]   <= '0;
        phase_reg[v]  <= '0;
        sample_reg[v] <= '0;
        wave_reg[v]   <= '0;
      end
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        if (write_sel[v]) begin
          ctrl_reg[v] <= bus.i_input;
        end
        if (slot_sel[v]) begin
          phase_reg[v]  <= phase_next;
          sample_reg[v] <= sample_next;
          wave_reg[v]   <= wave_next;
        end
      end
    end
  end

  // Round-robin slot counter; VOICES is a power of two so it wraps naturally.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      slot_reg <= '0;
    end else begin
      slot_reg <= slot_reg + VW'(1);
    end
  end

  // Registered address output, tagged with the voice it belongs to.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      bus.o_waveram_address <= '0;
      bus.o_voice           <= '0;
      bus.o_valid           <= 1'b0;
    end else begin
      bus.o_waveram_address <= {wave_next, sample_next};
      bus.o_voice           <= slot_reg;
      bus.o_valid           <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nco_voice_bank.sv
// Scoreboard bench for nco_voice_bank: a per-voice reference model pushes
// the expected {valid, voice, address} for every driven cycle and each
// scenario pops and compares after the edge.
module tb_nco_voice_bank;
  localparam int VOICES = 4;
  localparam int ACC_W  = 18;
  localparam int SMP_W  = 7;
  localparam int WAV_W  = 6;
  localparam int OCT_W  = 3;
  localparam int VW     = 2;
  localparam int CW     = ACC_W + OCT_W + WAV_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nco_voice_bank_if #(.VOICES(VOICES), .ACC_W(ACC_W), .SMP_W(SMP_W),
                      .WAV_W(WAV_W), .OCT_W(OCT_W), .VW(VW)) bus();

  nco_voice_bank #(.VOICES(VOICES), .ACC_W(ACC_W), .SMP_W(SMP_W),
                   .WAV_W(WAV_W), .OCT_W(OCT_W), .VW(VW)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Reference model state.
  int m_word   [VOICES];
  int m_phase  [VOICES];
  int m_sample [VOICES];
  int m_wave   [VOICES];
  int m_slot;
  logic [15:0] sb_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int mkword(input int inc, input int oct, input int wave);
    return (wave << (ACC_W + OCT_W)) | (oct << ACC_W) | inc;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < VOICES; v++) begin
      m_word[v] = 0; m_phase[v] = 0; m_sample[v] = 0; m_wave[v] = 0;
    end
    m_slot = 0;
    sb_q.delete();
  endtask

  task automatic model_service(input logic we, input int wv, input int word,
                               input logic [VOICES-1:0] pr);
    int v, inc, oct, req, s;
    v   = m_slot;
    inc = m_word[v] % (1 << ACC_W);
    oct = (m_word[v] >> ACC_W) % (1 << OCT_W);
    req = m_word[v] >> (ACC_W + OCT_W);
    if (pr[v]) begin
      m_phase[v] = 0; m_sample[v] = 0; m_wave[v] = req;
    end else begin
      s = m_phase[v] + inc;
      m_phase[v] = s % (1 << ACC_W);
      if (s >= (1 << ACC_W) && oct < SMP_W) begin
        s = m_sample[v] + (1 << oct);
        if (s >= (1 << SMP_W)) m_wave[v] = req;
        m_sample[v] = s % (1 << SMP_W);
      end
    end
    sb_q.push_back({1'b1, VW'(v), WAV_W'(m_wave[v]), SMP_W'(m_sample[v])});
    if (we) m_word[wv] = word;
    m_slot = (v + 1) % VOICES;
  endtask

  // Drive one cycle of stimulus, update the model, and step past the edge.
  task automatic drive_cycle(input logic we, input int wv, input int word,
                             input logic [VOICES-1:0] pr);
    bus.i_input_latch_write_enable = we;
    bus.i_write_voice              = VW'(wv);
    bus.i_input                    = CW'(word);
    bus.i_phase_reset              = pr;
    model_service(we, wv, word, pr);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp, got;
    drive_cycle(1'b1, 0, mkword('h30000, 0, 4), '0);
    for (int k = 0; k < 21; k++) begin
      if (k > 0) drive_cycle(1'b0, 0, 0, '0);
      exp = sb_q.pop_front(); got = {bus.o_valid, bus.o_voice, bus.o_waveram_address};
      n_checks++;
      if (got !== exp) $display("FAIL reset_prerun: got %h want %h", got, exp);
      else n_pass++;
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.o_valid);
    else n_pass++;
    n_checks++;
    if (bus.o_waveram_address !== '0) $display("FAIL reset_addr: got %h want 000", bus.o_waveram_address);
    else n_pass++;
    n_checks++;
    if (bus.o_voice !== '0) $display("FAIL reset_voice: got %0d want 0", bus.o_voice);
    else n_pass++;
    // A write presented while reset is held must be discarded.
    bus.i_input_latch_write_enable = 1'b1;
    bus.i_write_voice              = VW'(1);
    bus.i_input                    = CW'(mkword('h3FFFF, 0, 1));
    bus.i_phase_reset              = '1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b0) $display("FAIL reset_held_valid: got %b want 0", bus.o_valid);
    else n_pass++;
    bus.i_input_latch_write_enable = 1'b0;
    bus.i_phase_reset              = '0;
    model_reset();
    #2 rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      drive_cycle(1'b0, 0, 0, '0);
      exp = sb_q.pop_front(); got = {bus.o_valid, bus.o_voice, bus.o_waveram_address};
      n_checks++;
      if (got !== exp) $display("FAIL reset_release: got %h want %h", got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_basic_stepping();
    logic [15:0] exp, got;
    while (m_slot != 0) begin
      drive_cycle(1'b0, 0, 0, '0);
      exp = sb_q.pop_front(); got = {bus.o_valid, bus.o_voice, bus.o_waveram_address};
      n_checks++;
      if (got !== exp) $display("FAIL basic_align: got %h want %h", got, exp);
      else n_pass++;
    end
    for (int k = 0; k <= 1024; k++) begin
      if (k == 0) drive_cycle(1'b1, 0, mkword('h20000, 0, 5), '0);
      else        drive_cycle(1'b0, 0, 0, '0);
      exp = sb_q.pop_front(); got = {bus.o_valid, bus.o_voice, bus.o_waveram_address};
      n_checks++;
      if (got !== exp) $display("FAIL basic_stream: got %h want %h", got, exp);
      else n_pass++;
      if (k > 0 && k % 4 == 0 && k / 4 < 256) begin
        n_checks++;
        if (bus.o_waveram_address > 13'h07F)
          $display("FAIL basic_range: got %h want <= 07f", bus.o_waveram_address);
        else n_pass++;
      end
      if (k == 255 * 4) begin
        n_checks++;
        if (bus.o_waveram_address !== 13'h07F)
          $display("FAIL basic_last_sample: got %h want 07f", bus.o_waveram_address);
        else n_pass++;
      end
      if (k == 256 * 4) begin
        n_checks++;
        if (bus.o_waveram_address !== 13'h280)
          $display("FAIL basic_wrap_wave: got %h want 280", bus.o_waveram_address);
        else n_pass++;
      end
    end
  endtask

  task automatic test_octave_skip();
    logic [15:0] exp, got;
    int n;
    while (m_slot != 0) begin
      drive_cycle(1'b0, 0, 0, '0);
      exp = sb_q.pop_front(); got = {bus.o_valid, bus.o_voice, bus.o_waveram_address};
      n_checks++;
      if (got !== exp) $display("FAIL octave_align: got %h want %h", got, exp);
      else n_pass++;
    end
    for (int k = 0; k <= 125; k++) begin
      if (k == 0) drive_cycle(1'b1, 1, mkword('h20000, 3, 9), '0);
      else        drive_cycle(1'b0, 0, 0, '0);
      exp = sb_q.pop_front(); got = {bus.o_valid, bus.o_voice, bus.o_waveram_address};
      n_checks++;
      if (got !== exp) $display("FAIL octave3_stream: got %h want %h", got, exp);
      else n_pass++;
      n = (k - 1) / 4 + 1;
      if (k % 4 == 1 && n == 30) begin
        n_checks++;
        if (bus.o_waveram_address !== 13'h078)
          $display("FAIL octave3_sample120: got %h want 078", bus.o_waveram_address);
        else n_pass++;
      end
      if (k % 4 == 1 && n == 32) begin
        n_checks++;
        if (bus.o_waveram_address !== 13'h480)
          $display("FAIL octave3_wrap: got %h want 480", bus.o_waveram_address);
        else n_pass++;
      end
    end
    while (m_slot != 0) begin
      drive_cycle(1'b0, 0, 0, '0);
      exp = sb_q.pop_front(); got = {bus.o_valid, bus.o_voice, bus.o_waveram_address};
      n_checks++;
      if (got !== exp) $display("FAIL octave_align2: got %h want %h", got, exp);
      else n_pass++;
    end
    for (int k = 0; k <= 40; k++) begin
      if (k == 0) drive_cycle(1'b1, 1, mkword('h20000, 7, 9), '0);
      else        drive_cycle(1'b0, 0, 0, '0);
      exp = sb_q.pop_front(); got = {bus.o_valid, bus.o_voice, bus.o_waveram_address};
      n_checks++;
      if (got !== exp) $display("FAIL octave7_stream: got %h want %h", got, exp);
      else n_pass++;
      if (k % 4 == 1) begin
        n_checks++;
        if (bus.o_waveram_address !== 13'h480)
          $display("FAIL octave7_frozen: got %h want 480", bus.o_waveram_address);
        else n_pass++;
      end
    end
  endtask

  task automatic test_hard_sync();
    logic [15:0] exp, got;
    while (m_slot != 0) begin
      drive_cycle(1'b0, 0, 0, '0);
      exp = sb_q.pop_front(); got = {bus.o_valid, bus.o_voice, bus.o_waveram_address};
      n_checks++;
      if (got !== exp) $display("FAIL sync_align: got %h want %h", got, exp);
      else n_pass++;
    end
    for (int k = 0; k < 100; k++) begin
      if (k == 0)      drive_cycle(1'b1, 1, mkword('h10000, 2, 3), '0);
      else if (k == 1) drive_cycle(1'b1, 2, mkword('h0C000, 1, 12), '0);
      else             drive_cycle(1'b0, 0, 0, '0);
      exp = sb_q.pop_front(); got = {bus.o_valid, bus.o_voice, bus.o_waveram_address};
      n_checks++;
      if (got !== exp) $display("FAIL sync_prerun: got %h want %h", got, exp);
      else n_pass++;
    end
    // 100 cycles from slot 0 leave the counter at slot 0 again.
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b0, 0, 0, 4'b0100);
      exp = sb_q.pop_front(); got = {bus.o_valid, bus.o_voice, bus.o_waveram_address};
      n_checks++;
      if (got !== exp) $display("FAIL sync_pulse: got %h want %h", got, exp);
      else n_pass++;
      if (k == 2) begin
        n_checks++;
        if (bus.o_waveram_address !== 13'h600)
          $display("FAIL sync_restart: got %h want 600", bus.o_waveram_address);
        else n_pass++;
      end
    end
    for (int j = 0; j < 24; j++) begin
      drive_cycle(1'b0, 0, 0, '0);
      exp = sb_q.pop_front(); got = {bus.o_valid, bus.o_voice, bus.o_waveram_address};
      n_checks++;
      if (got !== exp) $display("FAIL sync_after: got %h want %h", got, exp);
      else n_pass++;
      if (j == 18) begin
        n_checks++;
        if (bus.o_waveram_address !== 13'h600)
          $display("FAIL sync_no_carry_yet: got %h want 600", bus.o_waveram_address);
        else n_pass++;
      end
      if (j == 22) begin
        n_checks++;
        if (bus.o_waveram_address !== 13'h602)
          $display("FAIL sync_first_carry: got %h want 602", bus.o_waveram_address);
        else n_pass++;
      end
    end
  endtask

  task automatic test_write_collision();
    logic [15:0] exp, got;
    while (m_slot != 3) begin
      drive_cycle(1'b0, 0, 0, '0);
      exp = sb_q.pop_front(); got = {bus.o_valid, bus.o_voice, bus.o_waveram_address};
      n_checks++;
      if (got !== exp) $display("FAIL collide_align: got %h want %h", got, exp);
      else n_pass++;
    end
    for (int k = 0; k <= 8; k++) begin
      if (k == 0) drive_cycle(1'b1, 3, mkword('h3FFFF, 0, 7), '0);
      else        drive_cycle(1'b0, 0, 0, '0);
      exp = sb_q.pop_front(); got = {bus.o_valid, bus.o_voice, bus.o_waveram_address};
      n_checks++;
      if (got !== exp) $display("FAIL collide_stream: got %h want %h", got, exp);
      else n_pass++;
      if (k == 0 || k == 4) begin
        n_checks++;
        if ({bus.o_voice, bus.o_waveram_address} !== {2'd3, 13'h000})
          $display("FAIL collide_no_carry: got voice %0d addr %h want voice 3 addr 000",
                   bus.o_voice, bus.o_waveram_address);
        else n_pass++;
      end
      if (k == 8) begin
        n_checks++;
        if ({bus.o_voice, bus.o_waveram_address} !== {2'd3, 13'h001})
          $display("FAIL collide_carry: got voice %0d addr %h want voice 3 addr 001",
                   bus.o_voice, bus.o_waveram_address);
        else n_pass++;
      end
    end
  endtask

  task automatic test_independence();
    logic [15:0] exp, got;
    int words [VOICES];
    words[0] = mkword('h01234, 0, 1);
    words[1] = mkword('h0ABCD, 1, 2);
    words[2] = mkword('h2FFFF, 2, 3);
    words[3] = mkword('h00777, 4, 60);
    for (int k = 0; k < 10004; k++) begin
      if (k < VOICES) drive_cycle(1'b1, k, words[k], '0);
      else            drive_cycle(1'b0, 0, 0, '0);
      exp = sb_q.pop_front(); got = {bus.o_valid, bus.o_voice, bus.o_waveram_address};
      n_checks++;
      if (got !== exp) $display("FAIL independence: cycle %0d got %h want %h", k, got, exp);
      else n_pass++;
    end
  endtask

  initial begin
    bus.i_input_latch_write_enable = 1'b0;
    bus.i_write_voice              = '0;
    bus.i_input                    = '0;
    bus.i_phase_reset              = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    test_reset();
    test_basic_stepping();
    test_octave_skip();
    test_hard_sync();
    test_write_collision();
    test_independence();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nco_voice_bank.md
# nco_voice_bank

Parametrised, time-multiplexed bank of numerically controlled oscillators that generates wavetable RAM addresses for `VOICES` independent voices. A single phase/sample/wave datapath is shared round-robin, serving one voice per clock. Compared with the single-voice NCO, it adds:
- configurable accumulator, wavesample and wave widths;
- per-voice hard-sync phase reset;
- fully synchronous wavesample stepping, with no derived clock edges;
- wave changes deferred to a true wavesample wrap.

It sits between the control-word interface and the wavetable RAM read port.

## Interface
Parameters:
- VOICES, 4, number of voices; power of two, ≥ 2
- ACC_W, 18, phase accumulator / increment width
- SMP_W, 7, wavesample address width (2^SMP_W samples per wave)
- WAV_W, 6, wave address width (2^WAV_W waves per table)
- OCT_W, 3, octave-select field width
- VW, $clog2(VOICES), voice index width (derived)

Ports:
- i_clock  in  1  single clock; all state changes on posedge
- i_reset  in  1  asynchronous, active-high reset
- i_input_latch_write_enable  in  1  load i_input into the control word of voice i_write_voice
- i_write_voice  in  VW  target voice for the write
- i_input  in  ACC_W+OCT_W+WAV_W  control word; fields: [ACC_W-1:0] increment, next OCT_W bits octave, top WAV_W bits requested wave
- i_phase_reset  in  VOICES  per-voice hard-sync request, one bit per voice
- o_waveram_address  out  WAV_W+SMP_W  {wave, wavesample} for o_voice
- o_voice  out  VW  voice to which o_waveram_address belongs
- o_valid  out  1  o_waveram_address/o_voice valid this cycle

## Operation
Per-voice state:
- control word: increment, octave, requested wave
- phase accumulator: ACC_W bits
- wavesample address: SMP_W bits
- active wave: WAV_W bits

Slot counter:
- VW bits, increments every clock, wraps VOICES-1 → 0.
- The voice equal to the slot counter is serviced this cycle.

Service of voice v:
- {carry, phase'} = phase + increment, computed at ACC_W+1 bits; phase' is truncated to ACC_W.
- Step value: 1 << octave when octave < SMP_W, otherwise 0. The sample address is frozen for octave ≥ SMP_W.
- If carry = 1: {wrap, sample'} = sample + step, computed at SMP_W+1 bits; otherwise sample' = sample and wrap = 0.
- If wrap = 1: active wave ← requested wave. This is the only time a wave changes in normal running.

Hard sync:
- If i_phase_reset[v] is high in v's slot, then phase ← 0, sample ← 0 and active wave ← requested wave. This overrides the carry/wrap result for that slot.
- i_phase_reset bits outside the serviced slot are ignored; no request is stored. Callers hold the bit for ≥ VOICES cycles.

Writes:
- A write updates only v's control word; phase, sample and wave are untouched.
- A write to the voice being serviced in the same cycle takes effect from that voice's next slot. The current slot uses the old control word.

Output:
- o_waveram_address = {active wave', sample'} of the serviced voice, registered.
- o_voice = slot, registered.
- o_valid = 1 from the first clock edge after reset is released.

Reset:
- Every control word, phase, sample, wave, the slot counter, o_waveram_address, o_voice and o_valid clear to 0 immediately, regardless of the clock.
- Reset asserted mid-operation discards any pending write and any phase-reset request.

## Timing
- One voice is serviced per clock, so each voice updates at f_clock/VOICES.
- Latency: the address for slot v appears on the clock edge that services v, and is valid for one cycle.
- o_voice sequence: 0,1,…,VOICES-1,0,…, with no gaps.
- The per-voice read-modify-write completes in a single cycle, with no stalls.
- Writes and phase resets are sampled on the same edge as servicing.
- Increment 0 holds the phase; the sample holds unless a phase reset occurs.
- Accumulator wrap is modulo 2^ACC_W. Sample wrap is modulo 2^SMP_W; wrap is asserted even when the wrap lands exactly on 0.
- Arithmetic is unsigned. There is no saturation.

## Test plan
All scenarios use default parameters.

- **Reset:**
  - Stimulus: run voices; assert i_reset between clock edges.
  - Response: o_valid=0, o_waveram_address=0, o_voice=0 at once.
  - Stimulus: release i_reset.
  - Response: first edge gives o_valid=1, o_voice=0.
- **Basic stepping:**
  - Stimulus: voice 0 written with increment 0x20000, octave 0, wave 5.
  - Response: voice-0 sample advances by 1 every 8 clocks (carry every second slot); address stays 0x000–0x07F.
  - Stimulus: continue to voice 0's 256th slot (sample wraps).
  - Response: voice 0 outputs 0x280 (wave 5, sample 0).
- **Octave skip:**
  - Stimulus: voice 1 with increment 0x20000 and octave 3.
  - Response: samples 0,8,16,…,120; the 16th carry wraps to 0 and changes the wave.
  - Stimulus: octave 7 instead.
  - Response: sample stays 0 despite carries.
- **Hard sync:**
  - Stimulus: voices 1 and 2 running; pulse i_phase_reset[2] for 4 cycles.
  - Response: voice 2 outputs {requested wave, 0} and its phase restarts from 0; voice 1's sequence is unchanged.
- **Write collision:**
  - Stimulus: write voice 3 increment 0x3FFFF in voice 3's own slot, with the old increment 0.
  - Response: that slot shows no change; the next voice-3 slot shows phase 0x3FFFF and no carry; the following voice-3 slot shows a carry.
- **Independence:**
  - Stimulus: four voices with distinct increments and waves for 10000 clocks.
  - Response: each voice's address stream matches a per-voice reference model exactly.
